key_matrix_scan: RTL and testbench
==================================

KEY_MATRIX_SCAN -- requirements
Module: key_matrix_scan

Interface
REQ-001 SHALL have parameter SETTLE_BITS, default 13; each row is driven for 2^SETTLE_BITS+1 clk cycles.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 3; this is the number of consecutive identical full scans required before a new key state is accepted; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit; the sole clock, and all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port colIn, input, 8 bits; asynchronous column sense lines, 1 = key closed on the currently driven row.
REQ-006 SHALL have port rowOut, output, 8 bits; one-hot row drive, with bit r high while row r is scanned.
REQ-007 SHALL have port keys, output, 64 bits; the debounced key state, bit 8*r+c = row r, column c, so row 0 is bits 7:0 and bit 0 is the right side of the top row.
REQ-008 SHALL have port keysChanged, output, 1 bit; a one-cycle pulse on the cycle keys takes a new value.
REQ-009 SHALL have port anyKey, output, 1 bit; it is high when any bit of the registered keys is 1.

Function
REQ-010 SHALL pass colIn through a 2-flop synchronizer before any use; no logic samples the raw colIn.
REQ-011 SHALL use a settle counter of width SETTLE_BITS+1 that increments every cycle and clears when its MSB is 1; that MSB-set cycle is the sample/advance cycle.
REQ-012 On the sample/advance cycle, SHALL capture the synchronized columns into the frame buffer bits 8*rowIdx+7:8*rowIdx.
REQ-013 On the same cycle, SHALL advance rowIdx by 1 modulo 8, with 7 wrapping to 0, and update rowOut to the next one-hot value.
REQ-014 rowOut SHALL be registered and always exactly one-hot, including during and after reset.
REQ-015 A frame completes on the row-7 sample cycle T; the completed frame is the buffer with row 7 replaced by the value sampled at T.
REQ-016 At T+1, if the completed frame equals the previous frame, SHALL increment stableCount, saturating at DEBOUNCE_SCANS.
REQ-017 At T+1, if the completed frame differs from the previous frame, SHALL clear stableCount to 0.
REQ-018 At T+1, SHALL store the completed frame as the previous frame in all cases.
REQ-019 At T+1, if stableCount reaches DEBOUNCE_SCANS through that increment and the completed frame differs from keys, SHALL load keys with the frame and assert keysChanged for that single cycle.
REQ-020 A frame identical to keys SHALL never pulse keysChanged; saturated stableCount with an unchanged frame SHALL cause no further updates.
REQ-021 keysChanged SHALL be low on every cycle other than those defined in REQ-019.
REQ-022 anyKey SHALL be registered and SHALL update in the same cycle as keys.
REQ-023 Minimum accept latency is 1+DEBOUNCE_SCANS complete frames of stable input after the input change is first sampled; there is no upper bound while the input bounces.
REQ-024 The arrangement SHALL allow keys to be wired directly to the LED driver data input so that the display mirrors the keypad with identical orientation.

Reset
REQ-025 While rst is high at a clock edge, SHALL set the settle counter to 0, rowIdx to 0, and rowOut to 8'b00000001.
REQ-026 While rst is high at a clock edge, SHALL clear keys, the frame buffer, the previous frame, stableCount, both synchronizer stages, keysChanged and anyKey to 0.
REQ-027 rst asserted mid-frame or mid-debounce SHALL discard the partial frame and all debounce history.
REQ-028 After rst deasserts, SHALL restart scanning at row 0 with a full settle period.

Verification (SETTLE_BITS=3, i.e. 9 cycles/row and 72 cycles/frame; DEBOUNCE_SCANS=2)
REQ-029 Reset with no keys pressed -> rowOut rotates 01,02,04,...,80,01 with a 9-cycle period; keys=0, keysChanged never pulses, anyKey=0.
REQ-030 Hold row 2/col 5 closed (colIn=8'h20 only while rowOut=8'h04) from reset -> keys=64'h0000_0000_0020_0000 after 3 frames; keysChanged pulses exactly once; anyKey=1.
REQ-031 Release that key -> after 3 stable frames keys=0, one keysChanged pulse, anyKey=0.
REQ-032 Close row 7/col 0 for exactly one frame, then open it -> keys stays 0 and keysChanged never pulses.
REQ-033 Alternate the input between two patterns every frame -> stableCount never exceeds 0 and keys is unchanged.
REQ-034 Assert rst for 1 cycle mid-frame while a key is debounced -> keys=0 and rowOut=01 the next cycle; the key is re-accepted 3 frames later with one keysChanged pulse.

Source files
------------

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: 8x8 key matrix scanner with per-row settle time and whole-frame debounce.
module key_matrix_scan #(
    parameter int SETTLE_BITS    = 13,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  colIn,
    output logic [7:0]  rowOut,
    output logic [63:0] keys,
    output logic        keysChanged,
    output logic        anyKey
);
    localparam logic [3:0] max_count = 4'(DEBOUNCE_SCANS);
    logic [7:0]             sync1, sync2;
    logic [SETTLE_BITS:0]   settle;
    logic [2:0]             row_idx;
    logic [63:0]            frame, prev;
    logic [3:0]             stable;
    logic                   done;
    logic                   sample;
    assign sample = settle[SETTLE_BITS];
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= '0;
            sync2       <= '0;
            settle      <= '0;
            row_idx     <= '0;
            rowOut      <= 8'b0000_0001;
            frame       <= '0;
            prev        <= '0;
            stable      <= '0;
            done        <= 1'b0;
            keys        <= '0;
            keysChanged <= 1'b0;
            anyKey      <= 1'b0;
        end else begin
            sync1       <= colIn;
            sync2       <= sync1;
            settle      <= sample ? '0 : settle + {{SETTLE_BITS{1'b0}}, 1'b1};
            done        <= sample && row_idx == 3'd7;
            keysChanged <= 1'b0;
            if (sample) begin
                frame[8*row_idx +: 8] <= sync2;
                row_idx               <= row_idx + 3'd1;
                rowOut                <= {rowOut[6:0], rowOut[7]};
            end
            // frame holds the completed scan one cycle after the row-7 sample
            if (done) begin
                prev <= frame;
                if (frame == prev) begin
                    if (stable != max_count)
                        stable <= stable + 4'd1;
                    if (stable + 4'd1 == max_count && frame != keys) begin
                        keys        <= frame;
                        anyKey      <= |frame;
                        keysChanged <= 1'b1;
                    end
                end else begin
                    stable <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_key_matrix_scan.sv
// tb_key_matrix_scan: directed scoreboard bench with a keypad model driving colIn from rowOut.
module tb_key_matrix_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  colIn, rowOut;
    logic [63:0] keys;
    logic [63:0] pressed = '0;
    logic        keysChanged, anyKey;

    typedef struct {
        logic [63:0] keys;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   k = 0;

    localparam logic [63:0] key_r2c5 = 64'h0000_0000_0020_0000;
    localparam logic [63:0] key_r7c0 = 64'h0100_0000_0000_0000;
    localparam logic [63:0] pat_a    = 64'h0000_0000_0000_0200;
    localparam logic [63:0] pat_b    = 64'h0000_0100_0000_0000;

    always #5 clk = ~clk;

    always_comb begin
        colIn = '0;
        for (int r = 0; r < 8; r++)
            if (rowOut[r]) colIn = colIn | pressed[8*r +: 8];
    end

    key_matrix_scan #(.SETTLE_BITS(3), .DEBOUNCE_SCANS(2)) dut (
        .clk(clk), .rst(rst), .colIn(colIn), .rowOut(rowOut),
        .keys(keys), .keysChanged(keysChanged), .anyKey(anyKey)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        exp_t       e;
        logic [7:0] er;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            er = 8'h01 << ((k / 9) % 8);
            check("rowOut", 64'(rowOut), 64'(er));
            if (keysChanged) begin
                if (sb.size() == 0) begin
                    check("spurious_keysChanged", {63'b0, keysChanged}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("keys_on_pulse", keys, e.keys);
                    check("anyKey_on_pulse", {63'b0, anyKey}, {63'b0, |e.keys});
                    if (e.cyc >= 0) check("accept_cycle", 64'(k), 64'(e.cyc));
                end
            end
        end
    endtask

    task automatic step_end(input string tag, input logic [63:0] exp_keys);
        check({tag, "_pending"}, 64'(sb.size()), 64'd0);
        check({tag, "_keys"}, keys, exp_keys);
        check({tag, "_anyKey"}, {63'b0, anyKey}, {63'b0, |exp_keys});
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        k = 0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_rowOut", 64'(rowOut), 64'h01);
        check("rst_keys", keys, 64'd0);
        check("rst_keysChanged", {63'b0, keysChanged}, 64'd0);
        check("rst_anyKey", {63'b0, anyKey}, 64'd0);
    endtask

    initial begin
        // idle scan: rotation and no activity
        do_reset();
        run(216);
        step_end("idle", 64'd0);
        // key held from reset: accepted on the third frame update
        pressed = key_r2c5;
        do_reset();
        sb.push_back('{key_r2c5, 217});
        run(288);
        step_end("press", key_r2c5);
        // release
        pressed = '0;
        sb.push_back('{64'd0, -1});
        run(360);
        step_end("release", 64'd0);
        // single-frame glitch is rejected
        pressed = key_r7c0;
        run(72);
        pressed = '0;
        run(288);
        step_end("glitch", 64'd0);
        // pattern alternating every frame never settles
        for (int i = 0; i < 6; i++) begin
            pressed = pat_a;
            run(72);
            pressed = pat_b;
            run(72);
        end
        pressed = '0;
        run(144);
        step_end("alternate", 64'd0);
        // accept, then reset mid-frame and re-accept
        pressed = key_r2c5;
        sb.push_back('{key_r2c5, -1});
        run(360);
        step_end("preaccept", key_r2c5);
        run(30);
        do_reset();
        sb.push_back('{key_r2c5, 217});
        run(288);
        step_end("reaccept", key_r2c5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
